// File: rtl/pll_lock_controller_pkg.sv
// pll_ctrl_pkg: shared state type, retry-counter width and counter sizing
// helper for the PLL lock controller.
package pll_ctrl_pkg;

    typedef enum logic [2:0] {
        RESET_PLL,
        WAIT_LOCK,
        STABLE,
        RUN,
        FAULT
    } pll_ctrl_state_t;

    localparam int RETRY_W = 4;

    // One counter serves every timed state, so it is sized for the longest
    // interval; the extra bit keeps terminal-count compares clear of wrap.
    function automatic int cnt_width(input int rst_pulse, input int lock_timeout,
                                     input int lock_stable);
        int m;
        m = rst_pulse;
        if (lock_timeout > m) m = lock_timeout;
        if (lock_stable > m) m = lock_stable;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/pll_lock_controller_if.sv
// pll_lock_controller_if: PLL-side status/control bundle of the lock
// controller. master = the controller, slave = the PLL and the consumers of
// the reset/status outputs.
interface pll_lock_controller_if;
    import pll_ctrl_pkg::*;

    logic               pll_locked;
    logic               pll_rst;
    logic               sys_rst;
    logic               pll_ready;
    logic               pll_fault;
    logic [RETRY_W-1:0] retry_count;

    modport master (
        input  pll_locked,
        output pll_rst,
        output sys_rst,
        output pll_ready,
        output pll_fault,
        output retry_count
    );

    modport slave (
        output pll_locked,
        input  pll_rst,
        input  sys_rst,
        input  pll_ready,
        input  pll_fault,
        input  retry_count
    );

endinterface

// File: rtl/pll_lock_controller_sync_2ff.sv
// sync_2ff: generic single-bit two-flop synchronizer for asynchronous status
// inputs, asynchronous active-high reset to 0.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two back-to-back flops give the first stage a full cycle to settle.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its source, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_controller.sv
// pll_lock_controller: reset-and-lock supervisor for the system PLL. Pulses
// the PLL reset, waits for lock with a bounded number of retries, debounces
// lock before releasing the downstream reset, and reports ready/fault.
// Build macro PLL_AUTO_RELOCK_EN: when defined, lock loss in RUN restarts the
// PLL bring-up; when undefined, lock loss in RUN latches FAULT.
module pll_lock_controller
    import pll_ctrl_pkg::*;
#(
    parameter int RST_PULSE_CYC    = 16,
    parameter int LOCK_TIMEOUT_CYC = 50000,
    parameter int LOCK_STABLE_CYC  = 1024,
    parameter int MAX_RETRIES      = 7
) (
    input  logic                  refclk,
    input  logic                  rst,
    pll_lock_controller_if.master bus
);

    localparam int CNT_W = cnt_width(RST_PULSE_CYC, LOCK_TIMEOUT_CYC, LOCK_STABLE_CYC);

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYC - 1);
    // The WAIT_LOCK cycle that first sees lk is the first stable cycle and the
    // edge into RUN is the last, so STABLE itself counts two fewer.
    localparam logic [CNT_W-1:0] STABLE_LAST  =
        CNT_W'((LOCK_STABLE_CYC >= 2) ? LOCK_STABLE_CYC - 2 : 0);
    localparam logic [RETRY_W-1:0] RETRY_MAX  = RETRY_W'(MAX_RETRIES);
    localparam logic [RETRY_W-1:0] RETRY_SAT  = {RETRY_W{1'b1}};

    pll_ctrl_state_t    state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic               pll_rst_q, pll_rst_d;
    logic               sys_rst_q, sys_rst_d;
    logic               ready_q, ready_d;
    logic               fault_q, fault_d;
    logic               lk;

    sync_2ff u_lock_sync (
        .clk (refclk),
        .rst (rst),
        .d_i (bus.pll_locked),
        .q_o (lk)
    );

    // State, shared counter and retry count registers.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q <= RESET_PLL;
            cnt_q   <= '0;
            retry_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            retry_q <= retry_d;
        end
    end

    // Next-state, counter and retry decisions from the synchronized lock flag.
    // NOTE: every signal assigned in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;
        case (state_q)
            RESET_PLL: begin
                if (cnt_q == RST_LAST) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT_LOCK: begin
                // Lock is tested first so it wins on the timeout cycle.
                if (lk) begin
                    state_d = STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    cnt_d = '0;
                    if (retry_q == RETRY_MAX) begin
                        state_d = FAULT;
                    end else begin
                        state_d = RESET_PLL;
                        retry_d = (retry_q == RETRY_SAT) ? retry_q : retry_q + RETRY_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STABLE: begin
                // A dropout restarts the wait window but is not a failed attempt.
                if (!lk) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q >= STABLE_LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    retry_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RUN: begin
                if (!lk) begin
                    cnt_d = '0;
`ifdef PLL_AUTO_RELOCK_EN
                    state_d = RESET_PLL;
`else
                    state_d = FAULT;
`endif
                end
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: begin
                state_d = RESET_PLL;
                cnt_d   = '0;
            end
        endcase
    end

    // Output decode of the next state, so registered outputs change on the
    // same edge that enters the new state.
    always_comb begin
        pll_rst_d = 1'b1;
        sys_rst_d = 1'b1;
        ready_d   = 1'b0;
        fault_d   = 1'b0;
        case (state_d)
            WAIT_LOCK, STABLE: begin
                pll_rst_d = 1'b0;
            end
            RUN: begin
                pll_rst_d = 1'b0;
                sys_rst_d = 1'b0;
                ready_d   = 1'b1;
            end
            FAULT: begin
                fault_d = 1'b1;
            end
            default: begin
                pll_rst_d = 1'b1;
            end
        endcase
    end

    // Output registers; reset holds both resets asserted and status cleared.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            pll_rst_q <= 1'b1;
            sys_rst_q <= 1'b1;
            ready_q   <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            pll_rst_q <= pll_rst_d;
            sys_rst_q <= sys_rst_d;
            ready_q   <= ready_d;
            fault_q   <= fault_d;
        end
    end

    assign bus.pll_rst     = pll_rst_q;
    assign bus.sys_rst     = sys_rst_q;
    assign bus.pll_ready   = ready_q;
    assign bus.pll_fault   = fault_q;
    assign bus.retry_count = retry_q;

endmodule

// File: tb/tb_pll_lock_controller.sv
// tb_pll_lock_controller: directed and randomized bench for the PLL lock
// controller, with a behavioural reference model compared on every cycle.
module tb_pll_lock_controller;

    localparam int P = 4;    // reset pulse cycles
    localparam int T = 100;  // lock timeout cycles
    localparam int S = 16;   // stable-lock cycles
    localparam int M = 2;    // tolerated failed attempts

    localparam int PH_RST    = 0;
    localparam int PH_WAIT   = 1;
    localparam int PH_STABLE = 2;
    localparam int PH_RUN    = 3;
    localparam int PH_FAULT  = 4;

    logic refclk = 1'b0;
    logic rst    = 1'b0;
    int   checks = 0;
    int   errors = 0;
    bit   model_on = 1'b0;

    pll_lock_controller_if bus ();

    pll_lock_controller #(
        .RST_PULSE_CYC    (P),
        .LOCK_TIMEOUT_CYC (T),
        .LOCK_STABLE_CYC  (S),
        .MAX_RETRIES      (M)
    ) dut (
        .refclk (refclk),
        .rst    (rst),
        .bus    (bus)
    );

    always #10 refclk = ~refclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // Phase plus "edges spent in this phase" and "consecutive locked cycles".
    int   m_phase, m_age, m_run, m_retry;
    logic m_h0, m_h1, m_lk;

    initial begin
        m_phase = PH_RST; m_age = 0; m_run = 0; m_retry = 0;
        m_h0 = 1'b0; m_h1 = 1'b0; m_lk = 1'b0;
        forever begin
            @(posedge refclk or posedge rst);
            if (rst) begin
                m_phase = PH_RST; m_age = 0; m_run = 0; m_retry = 0;
                m_h0 = 1'b0; m_h1 = 1'b0;
            end else begin
                m_lk = m_h1;
                m_h1 = m_h0;
                m_h0 = bus.pll_locked;
                m_age++;
                case (m_phase)
                    PH_RST: if (m_age == P) begin m_phase = PH_WAIT; m_age = 0; end
                    PH_WAIT: begin
                        if (m_lk) begin
                            m_phase = PH_STABLE; m_age = 0; m_run = 1;
                        end else if (m_age == T) begin
                            m_age = 0;
                            if (m_retry == M) m_phase = PH_FAULT;
                            else begin
                                m_retry = (m_retry < 15) ? m_retry + 1 : 15;
                                m_phase = PH_RST;
                            end
                        end
                    end
                    PH_STABLE: begin
                        if (!m_lk) begin
                            m_phase = PH_WAIT; m_age = 0;
                        end else begin
                            m_run++;
                            if (m_run >= S) begin m_phase = PH_RUN; m_retry = 0; end
                        end
                    end
                    PH_RUN: begin
                        if (!m_lk) begin
                            m_age = 0;
`ifdef PLL_AUTO_RELOCK_EN
                            m_phase = PH_RST;
`else
                            m_phase = PH_FAULT;
`endif
                        end
                    end
                    default: m_phase = PH_FAULT;
                endcase
            end
        end
    end

    // Compare every cycle, away from the active edge.
    initial begin
        forever begin
            @(negedge refclk);
            if (model_on) begin
                check("cmp_pll_rst",   bus.pll_rst,   (m_phase == PH_RST || m_phase == PH_FAULT));
                check("cmp_sys_rst",   bus.sys_rst,   (m_phase != PH_RUN));
                check("cmp_pll_ready", bus.pll_ready, (m_phase == PH_RUN));
                check("cmp_pll_fault", bus.pll_fault, (m_phase == PH_FAULT));
                check("cmp_retry",     bus.retry_count, m_retry);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge refclk);
        #2;
    endtask

    function automatic logic get_sig(input int sel);
        case (sel)
            0:       return bus.pll_rst;
            1:       return bus.sys_rst;
            2:       return bus.pll_ready;
            default: return bus.pll_fault;
        endcase
    endfunction

    // Count rising edges until the selected output reaches val; -1 if the bound expires.
    task automatic edges_until(input int sel, input logic val, input int bound, output int n);
        n = 0;
        do begin
            @(posedge refclk);
            #1;
            n++;
        end while (get_sig(sel) !== val && n < bound);
        if (get_sig(sel) !== val) n = -1;
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_pll_rst"},   bus.pll_rst,     1);
        check({tag, "_sys_rst"},   bus.sys_rst,     1);
        check({tag, "_pll_ready"}, bus.pll_ready,   0);
        check({tag, "_pll_fault"}, bus.pll_fault,   0);
        check({tag, "_retry"},     bus.retry_count, 0);
    endtask

    task automatic do_reset();
        @(posedge refclk);
        #2;
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
    endtask

    // Assert rst between edges and expect reset values before any clock edge.
    task automatic reset_mid_cycle(input string tag);
        @(posedge refclk);
        #5;
        rst = 1'b1;
        #1;
        check_reset_values(tag);
        tick(2);
        rst = 1'b0;
    endtask

    task automatic run_no_lock();
        int   lows[$];
        int   highs[$];
        int   rise_retry[$];
        int   lowlen, hlen, rises, fault_edge;
        logic prev;
        lowlen = 0; hlen = 0; rises = 0; fault_edge = -1; prev = 1'b1;
        bus.pll_locked = 1'b0;
        do_reset();
        for (int e = 1; e <= 400; e++) begin
            @(posedge refclk);
            #1;
            if (bus.pll_fault === 1'b1) begin
                fault_edge = e;
                break;
            end
            if (bus.pll_rst === 1'b0) begin
                if (prev === 1'b1 && rises > 0) highs.push_back(hlen);
                lowlen++;
            end else if (prev === 1'b0) begin
                rises++;
                lows.push_back(lowlen);
                rise_retry.push_back(int'(bus.retry_count));
                lowlen = 0;
                hlen   = 1;
            end else begin
                hlen++;
            end
            prev = bus.pll_rst;
        end
        #1;
        check("nolock_fault_edge",    fault_edge, 312);
        check("nolock_retry_pulses",  rises, 2);
        check("nolock_gap1",          (lows.size() > 0) ? lows[0] : -1, 100);
        check("nolock_gap2",          (lows.size() > 1) ? lows[1] : -1, 100);
        check("nolock_gap3",          lowlen, 100);
        check("nolock_pulse2_len",    (highs.size() > 0) ? highs[0] : -1, 4);
        check("nolock_pulse3_len",    (highs.size() > 1) ? highs[1] : -1, 4);
        check("nolock_retry_after1",  (rise_retry.size() > 0) ? rise_retry[0] : -1, 1);
        check("nolock_retry_after2",  (rise_retry.size() > 1) ? rise_retry[1] : -1, 2);
        check("fault_retry",          bus.retry_count, 2);
        check("fault_pll_rst",        bus.pll_rst, 1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int n;
        bus.pll_locked = 1'b0;
        #1;
        rst = 1'b1;
        model_on = 1'b1;
        #1;
        check_reset_values("power_on");
        tick(2);
        rst = 1'b0;

        // Bring-up: reset pulse length, lock 10 cycles later, RUN latency.
        edges_until(0, 1'b0, 50, n);
        check("bringup_pll_rst_len", n, 4);
        tick(10);
        bus.pll_locked = 1'b1;
        edges_until(2, 1'b1, 100, n);
        check("bringup_lock_to_ready", n, 18);
        check("bringup_sys_rst", bus.sys_rst, 0);
        check("bringup_retry", bus.retry_count, 0);

        // Lock loss while running.
        tick(5);
        bus.pll_locked = 1'b0;
        edges_until(1, 1'b1, 20, n);
        check("loss_to_sys_rst", n, 3);
`ifdef PLL_AUTO_RELOCK_EN
        check("relock_pll_rst", bus.pll_rst, 1);
        check("relock_retry", bus.retry_count, 0);
        edges_until(0, 1'b0, 20, n);
        check("relock_pulse_len", n, 4);
`else
        check("loss_fault", bus.pll_fault, 1);
        check("loss_pll_rst", bus.pll_rst, 1);
`endif

        // No lock at all: bounded retries then FAULT; rst mid-FAULT restarts.
        run_no_lock();
        tick(3);
        reset_mid_cycle("rst_in_fault");
        edges_until(0, 1'b0, 50, n);
        check("restart_after_fault_pulse", n, 4);
        check("restart_after_fault_retry", bus.retry_count, 0);

        // Lock dropout during STABLE: RUN only after 16 consecutive cycles.
        bus.pll_locked = 1'b0;
        do_reset();
        edges_until(0, 1'b0, 50, n);
        bus.pll_locked = 1'b1;
        tick(10);
        bus.pll_locked = 1'b0;
        tick(3);
        bus.pll_locked = 1'b1;
        edges_until(2, 1'b1, 100, n);
        check("glitch_second_rise_to_ready", n, 18);
        check("glitch_retry", bus.retry_count, 0);

        // rst in the middle of STABLE; lock held high across the restart.
        bus.pll_locked = 1'b0;
        do_reset();
        edges_until(0, 1'b0, 50, n);
        bus.pll_locked = 1'b1;
        tick(8);
        reset_mid_cycle("rst_in_stable");
        edges_until(0, 1'b0, 50, n);
        check("restart_after_stable_pulse", n, 4);
        edges_until(2, 1'b1, 100, n);
        check("restart_after_stable_to_ready", n, 16);

        // Lock seen exactly on the timeout cycle wins.
        bus.pll_locked = 1'b0;
        do_reset();
        edges_until(0, 1'b0, 50, n);
        tick(97);
        bus.pll_locked = 1'b1;
        tick(3);
        check("edge_lock_pll_rst", bus.pll_rst, 0);
        check("edge_lock_retry", bus.retry_count, 0);
        edges_until(2, 1'b1, 100, n);
        check("edge_lock_to_ready", n, 15);

        // One cycle later the attempt has already failed.
        bus.pll_locked = 1'b0;
        do_reset();
        edges_until(0, 1'b0, 50, n);
        tick(98);
        bus.pll_locked = 1'b1;
        tick(2);
        check("late_lock_pll_rst", bus.pll_rst, 1);
        check("late_lock_retry", bus.retry_count, 1);

        // Randomized lock behaviour with occasional asynchronous resets.
        for (int ep = 0; ep < 6; ep++) begin
            bus.pll_locked = 1'b0;
            do_reset();
            for (int k = 0; k < 40; k++) begin
                int len;
                int pick;
                pick = int'($urandom_range(0, 9));
                if (pick < 3)      len = int'($urandom_range(1, 4));
                else if (pick < 8) len = int'($urandom_range(5, 40));
                else               len = int'($urandom_range(90, 140));
                bus.pll_locked = ($urandom_range(0, 1) == 1) ? 1'b1 : 1'b0;
                tick(len);
                if ($urandom_range(0, 29) == 0) reset_mid_cycle("rand_rst");
            end
        end

        tick(5);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1);
    end

endmodule
